// File: rtl/time_dmr_retry_start.sv
// time_dmr_retry_start
// Front-end of the time-redundant retry loop. New upstream items are tagged
// with a sequential ID and remembered in an ID-indexed table. When the
// downstream checker reports a faulty ID, the stored payload is re-issued
// under the same ID, up to MaxRetries times per ID. Retries take priority
// over new upstream items. A single output register feeds downstream.

module time_dmr_retry_start #(
  parameter type         DataType   = logic,
  parameter int unsigned IdSize     = 4,
  parameter int unsigned MaxRetries = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IdSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IdSize-1:0] retry_id_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o,
  output logic              retry_drop_o
);

  localparam int unsigned NumEntries = 2 ** IdSize;
  // Counter must be able to hold the value MaxRetries itself.
  localparam int unsigned CntW       = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetries);

  // Saturating increment of a per-entry retry count; the re-issue condition
  // already prevents counting past MaxCnt, saturation is a second guard.
  function automatic logic [CntW-1:0] cnt_inc(input logic [CntW-1:0] cnt);
    logic [CntW-1:0] res;
    if (cnt >= MaxCnt) begin
      res = MaxCnt;
    end else begin
      res = cnt + CntW'(1);
    end
    return res;
  endfunction

  // ID counter and retry table state
  logic [IdSize-1:0]     id_cnt_r;
  DataType               tbl_data_r  [NumEntries];
  logic [NumEntries-1:0] tbl_valid_r;
  logic [CntW-1:0]       tbl_cnt_r   [NumEntries];

  // Combinational view of the entry addressed by the retry request
  DataType               rd_data_s;
  logic                  rd_valid_s;
  logic [CntW-1:0]       rd_cnt_s;

  // Arbitration and handshake decode
  logic                  stage_free_s;
  logic                  retry_pref_s;
  logic                  new_hs_s;
  logic                  retry_hs_s;
  logic                  retry_ok_s;
  logic                  reissue_s;
  logic                  drop_s;

  // Read the table entry selected by the retry ID (no write can collide).
  always_comb begin
    rd_data_s  = tbl_data_r[retry_id_i];
    rd_valid_s = tbl_valid_r[retry_id_i];
    rd_cnt_s   = tbl_cnt_r[retry_id_i];
  end

  // Decide which source may load the output stage this cycle.
  always_comb begin
    stage_free_s  = 1'b0;
    retry_pref_s  = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = 1'b0;

    stage_free_s = (~valid_o) | ready_i;
    retry_pref_s = enable_i & retry_valid_i;

    if (stage_free_s) begin
      ready_o = ~retry_pref_s;
    end else begin
      ready_o = 1'b0;
    end

    // With redundancy off every retry is swallowed immediately.
    if (!enable_i) begin
      retry_ready_o = 1'b1;
    end else if (stage_free_s) begin
      retry_ready_o = retry_valid_i;
    end else begin
      retry_ready_o = 1'b0;
    end
  end

  // Classify the handshakes that complete this cycle.
  always_comb begin
    new_hs_s   = 1'b0;
    retry_hs_s = 1'b0;
    retry_ok_s = 1'b0;
    reissue_s  = 1'b0;
    drop_s     = 1'b0;

    new_hs_s   = valid_i & ready_o;
    // Retries accepted while disabled are neither re-issued nor reported.
    retry_hs_s = retry_valid_i & retry_ready_o & enable_i;
    retry_ok_s = rd_valid_s & (rd_cnt_s < MaxCnt);

    if (retry_hs_s) begin
      reissue_s = retry_ok_s;
      drop_s    = ~retry_ok_s;
    end else begin
      reissue_s = 1'b0;
      drop_s    = 1'b0;
    end
  end

  // Sequential ID allocation; wraps modulo the table size.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      id_cnt_r <= '0;
    end else if (new_hs_s) begin
      id_cnt_r <= id_cnt_r + IdSize'(1);
    end else begin
      id_cnt_r <= id_cnt_r;
    end
  end

  // Table maintenance: record new items, count re-issues.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tbl_valid_r <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        tbl_data_r[i] <= '0;
        tbl_cnt_r[i]  <= '0;
      end
    end else if (new_hs_s) begin
      // Overwriting an old entry on wrap-around also restarts its count.
      tbl_data_r[id_cnt_r]  <= data_i;
      tbl_valid_r[id_cnt_r] <= 1'b1;
      tbl_cnt_r[id_cnt_r]   <= '0;
    end else if (reissue_s) begin
      tbl_cnt_r[retry_id_i] <= cnt_inc(rd_cnt_s);
    end else begin
      tbl_valid_r <= tbl_valid_r;
    end
  end

  // Output register: load a re-issue or a new item, else drain on ready_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o  <= '0;
      id_o    <= '0;
      valid_o <= 1'b0;
    end else if (reissue_s) begin
      data_o  <= rd_data_s;
      id_o    <= retry_id_i;
      valid_o <= 1'b1;
    end else if (new_hs_s) begin
      data_o  <= data_i;
      id_o    <= id_cnt_r;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end else begin
      // Stalled: hold payload and ID stable.
      valid_o <= valid_o;
    end
  end

  // Report a discarded retry one cycle after it was accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      retry_drop_o <= 1'b0;
    end else begin
      retry_drop_o <= drop_s;
    end
  end

endmodule

// File: tb/tb_time_dmr_retry_start.sv
// Directed bench for time_dmr_retry_start. Stimulus pushes expected output
// items into a scoreboard queue; a monitor pops and compares on every
// downstream transfer and also checks stability while stalled.

module tb_time_dmr_retry_start;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic [3:0] id_out;
  logic       valid_out;
  logic       ready_in;
  logic [3:0] retry_id;
  logic       retry_valid;
  logic       retry_ready;
  logic       retry_drop;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   obs_drops   = 0;
  int   exp_drops   = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] held_d;
  logic [3:0] held_id;

  time_dmr_retry_start #(
    .DataType  (logic [7:0]),
    .IdSize    (4),
    .MaxRetries(3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .data_i       (data_in),
    .valid_i      (valid_in),
    .ready_o      (ready_out),
    .data_o       (data_out),
    .id_o         (id_out),
    .valid_o      (valid_out),
    .ready_i      (ready_in),
    .retry_id_i   (retry_id),
    .retry_valid_i(retry_valid),
    .retry_ready_o(retry_ready),
    .retry_drop_o (retry_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    retry_valid = 1'b0;
    ready_in    = 1'b1;
    enable      = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: compare each downstream transfer against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, valid_out}, 32'd1);
        check("stall_hold", {20'd0, data_out, id_out}, {20'd0, held_d, held_id});
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {20'd0, data_out, id_out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_item", {20'd0, data_out, id_out}, {20'd0, e.d, e.id});
        end
      end
      prev_stall = valid_out && !ready_in;
      held_d     = data_out;
      held_id    = id_out;
      if (retry_drop) obs_drops++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'hA5;
    seq[1] = 8'h3C;
    seq[2] = 8'h7E;
    data_in  = 8'h00;
    retry_id = 4'd0;
    do_reset();

    // Reset state
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_id", {28'd0, id_out}, 32'd0);
    check("rst_drop", {31'd0, retry_drop}, 32'd0);

    // Plain sequence A5,3C,7E -> ids 0,1,2 one cycle after each accept
    for (int i = 0; i < 3; i++) begin
      data_in  = seq[i];
      valid_in = 1'b1;
      exp_q.push_back('{d: seq[i], id: 4'(i)});
      @(negedge clk);
      check("t1_ready", {31'd0, ready_out}, 32'd1);
      step();
      check("t1_valid", {31'd0, valid_out}, 32'd1);
    end
    valid_in = 1'b0;
    step();
    check("t1_idle", {31'd0, valid_out}, 32'd0);
    check("t1_drops", obs_drops, exp_drops);

    // Retry id1 beats new data 99; 99 follows as id3
    retry_id    = 4'd1;
    retry_valid = 1'b1;
    data_in     = 8'h99;
    valid_in    = 1'b1;
    exp_q.push_back('{d: 8'h3C, id: 4'd1});
    @(negedge clk);
    check("t2_ready", {31'd0, ready_out}, 32'd0);
    check("t2_rready", {31'd0, retry_ready}, 32'd1);
    step();
    retry_valid = 1'b0;
    exp_q.push_back('{d: 8'h99, id: 4'd3});
    @(negedge clk);
    check("t2_ready2", {31'd0, ready_out}, 32'd1);
    step();
    valid_in = 1'b0;
    step();

    // Retry id0 four times: three re-issues then one drop
    retry_id    = 4'd0;
    retry_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) exp_q.push_back('{d: 8'hA5, id: 4'd0});
      else exp_drops++;
      @(negedge clk);
      check("t3_rready", {31'd0, retry_ready}, 32'd1);
      step();
    end
    retry_valid = 1'b0;
    check("t3_drop", {31'd0, retry_drop}, 32'd1);
    check("t3_novalid", {31'd0, valid_out}, 32'd0);
    step();
    check("t3_drop_end", {31'd0, retry_drop}, 32'd0);

    // Never-written id9 straight after reset
    do_reset();
    retry_id    = 4'd9;
    retry_valid = 1'b1;
    exp_drops++;
    @(negedge clk);
    check("t4_rready", {31'd0, retry_ready}, 32'd1);
    step();
    retry_valid = 1'b0;
    check("t4_novalid", {31'd0, valid_out}, 32'd0);
    check("t4_drop", {31'd0, retry_drop}, 32'd1);
    step();
    check("t4_drops", obs_drops, exp_drops);

    // Backpressure for 5 cycles with both sources requesting
    ready_in = 1'b0;
    data_in  = 8'h11;
    valid_in = 1'b1;
    exp_q.push_back('{d: 8'h11, id: 4'd0});
    step();
    data_in     = 8'h22;
    retry_id    = 4'd0;
    retry_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_ready", {31'd0, ready_out}, 32'd0);
      check("t5_rready", {31'd0, retry_ready}, 32'd0);
      step();
    end
    ready_in = 1'b1;
    exp_q.push_back('{d: 8'h11, id: 4'd0});
    @(negedge clk);
    check("t5_rready_go", {31'd0, retry_ready}, 32'd1);
    check("t5_ready_go", {31'd0, ready_out}, 32'd0);
    step();
    retry_valid = 1'b0;
    exp_q.push_back('{d: 8'h22, id: 4'd1});
    step();
    valid_in = 1'b0;
    step();

    // Wrap: 17 items, 17th gets id0, retry id0 returns the 17th payload
    do_reset();
    for (int i = 0; i < 17; i++) begin
      data_in  = 8'h40 + 8'(i);
      valid_in = 1'b1;
      exp_q.push_back('{d: 8'h40 + 8'(i), id: 4'(i)});
      step();
    end
    valid_in    = 1'b0;
    retry_id    = 4'd0;
    retry_valid = 1'b1;
    exp_q.push_back('{d: 8'h50, id: 4'd0});
    step();
    retry_valid = 1'b0;
    step();

    // Redundancy disabled: new data still gets an ID, retry swallowed
    enable      = 1'b0;
    retry_id    = 4'd0;
    retry_valid = 1'b1;
    data_in     = 8'h5A;
    valid_in    = 1'b1;
    exp_q.push_back('{d: 8'h5A, id: 4'd1});
    @(negedge clk);
    check("t7_rready", {31'd0, retry_ready}, 32'd1);
    check("t7_ready", {31'd0, ready_out}, 32'd1);
    step();
    retry_valid = 1'b0;
    valid_in    = 1'b0;
    enable      = 1'b1;
    check("t7_nodrop", {31'd0, retry_drop}, 32'd0);
    step();

    // Reset while an item is held in the output stage
    ready_in = 1'b0;
    data_in  = 8'h77;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("t6_held", {31'd0, valid_out}, 32'd1);
    do_reset();
    check("t6_rst_valid", {31'd0, valid_out}, 32'd0);
    data_in  = 8'h88;
    valid_in = 1'b1;
    exp_q.push_back('{d: 8'h88, id: 4'd0});
    step();
    valid_in = 1'b0;
    step();
    step();

    check("queue_empty", exp_q.size(), 32'd0);
    check("drop_count", obs_drops, exp_drops);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_dmr_retry_start.md
Name: time_dmr_retry_start

Overview:
- Upstream front-end of the time-redundant retry loop; sits directly upstream of time_DMR_start.
- Tags each new transaction with a sequential ID and keeps a copy of its data in an ID-indexed table.
- Accepts retry requests carrying the ID of a transaction that the downstream checker flagged faulty, and re-issues the stored data under the same ID.
- Retried items take priority over new upstream items.

Parameters:
- DataType, logic, payload type.
- IdSize, 4, ID width; the table holds 2**IdSize entries.
- MaxRetries, 3, number of re-issues allowed per ID before the retry is refused.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- enable_i  in  1  redundancy enable; 0 disables retry handling
- data_i  in  DataType  upstream payload
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  DataType  downstream payload
- id_o  out  IdSize  downstream transaction ID
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_i  in  IdSize  ID to re-issue
- retry_valid_i  in  1  retry request valid
- retry_ready_o  out  1  retry request ready
- retry_drop_o  out  1  one-cycle pulse when an accepted retry is discarded

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset state: all flops cleared on the rising clk_i edge while rst_ni=0.
  - Outputs: valid_o=0, data_o=0, id_o=0, retry_drop_o=0.
  - Internal: ID counter=0, all table valid bits=0, all per-entry retry counters=0.
- Reset mid-transfer: any registered output item is discarded, and there is no replay after reset.
- Output stage: a single register (data_o, id_o, valid_o).
  - The stage is "free" when valid_o=0, or when valid_o=1 and ready_i=1.
  - While valid_o=1 and ready_i=0, data_o and id_o are held stable.
- Arbitration each cycle, when the stage is free:
  - Retry first: if enable_i=1 and retry_valid_i=1, then retry_ready_o=1 and ready_o=0.
  - Otherwise new data: ready_o=1 and retry_ready_o=0.
  - When the stage is not free: ready_o=0 and retry_ready_o=0, except in the enable_i=0 case below.
- New-item handshake (valid_i & ready_o):
  - Load data_i into the output stage with id_o = ID counter.
  - Write table[counter]: data = data_i, valid = 1, retry count = 0.
  - Increment the counter modulo 2**IdSize.
  - Latency is one cycle: valid_o is asserted in the cycle after the handshake.
- Retry handshake (retry_valid_i & retry_ready_o), with r = retry_id_i:
  - Re-issue when table[r].valid=1 and table[r].retry count < MaxRetries:
    - Load table[r].data into the output stage with id_o = r.
    - Increment the retry count.
    - The ID counter is unchanged.
  - Drop otherwise (entry invalid or count exhausted):
    - Nothing is loaded and the output stage stays free.
    - retry_drop_o pulses high in the next cycle.
    - The entry is not modified.
- Retry table read: combinational from retry_id_i. A table write and a retry read of the same index in the same cycle cannot occur, because the two handshakes are mutually exclusive.
- ID wrap-around: the counter wraps from 2**IdSize-1 to 0 and silently overwrites the old entry, resetting its retry count. The integrator guarantees that fewer than 2**IdSize items are in flight.
- enable_i=0:
  - New data passes through with IDs still assigned.
  - retry_ready_o=1 unconditionally and retries are dropped silently (no retry_drop_o pulse).
- enable_i toggling: does not flush the table.

Test Plan:
- Sequence without retries:
  - Stimulus: after reset, push bytes A5,3C,7E with ready_i=1 throughout.
  - Required: valid_o=1 with (A5,id0), (3C,id1), (7E,id2) on consecutive cycles, each one cycle after its accept; retry_drop_o=0 throughout.
- Retry of an issued ID:
  - Stimulus: after id1=3C has been issued, assert retry_id_i=1 and retry_valid_i=1 while valid_i=1 with new data 99.
  - Required: the retry wins; output is (3C,id1); ready_o=0 that cycle; 99 goes out as id3 in the following cycle.
- Retry limit:
  - Stimulus: request retry of id0 four times with MaxRetries=3.
  - Required: three re-issues of (A5,id0); the fourth retry is accepted and retry_drop_o pulses once with no output.
- Never-written ID:
  - Stimulus: retry id9 immediately after reset.
  - Required: retry_ready_o=1, no valid_o, retry_drop_o=1 the next cycle.
- Backpressure:
  - Stimulus: ready_i=0 for 5 cycles while valid_i=1 and retry_valid_i=1.
  - Required: valid_o held with stable data_o and id_o; ready_o=0 and retry_ready_o=0 until ready_i returns high.
- Wrap and reset:
  - Stimulus: push 17 items with IdSize=4, then retry id0; separately, assert rst_ni=0 while valid_o=1.
  - Required: the 17th item carries id0 and the retry re-issues the 17th item's data; after reset valid_o=0 and the next new item gets id0.
